inst_enc: RTL and testbench

- Instruction encoder: the producer of the 32-bit RV32 words that the instruction decoder consumes.
- Takes an operation kind plus register and immediate fields over a valid/ready handshake.
- Packs each into a standard RV32I/M instruction word, buffers it in a small FIFO, and writes words to instruction memory at consecutive word addresses.
- Used by the program loader and the CPU test benches to fill instruction memory.

---
 rtl/inst_enc.sv | 155 +++++++++++++++
 tb/tb_inst_enc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_enc.sv
// rtl/inst_enc.sv - RV32I/M instruction encoder feeding instruction memory through a small FIFO
module inst_enc #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        mem_wen_I,
    output logic [31:0] mem_addr_I,
    output logic [31:0] mem_wdata_I,
    input  logic        mem_ack_I,
    output logic        err_illegal,
    output logic [15:0] words_written
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [31:0]   r_fifo [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_addr;
    logic          r_err;
    logic [15:0]   r_words;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_i_ok;
    logic        w_b_ok;
    logic        w_j_ok;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    // Range checks reduce to "all upper bits equal the sign bit".
    assign w_i_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign w_b_ok = !in_imm[0] && ((in_imm[31:12] == '0) || (in_imm[31:12] == '1));
    assign w_j_ok = !in_imm[0] && ((in_imm[31:20] == '0) || (in_imm[31:20] == '1));

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (in_kind)
            4'd0:  w_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
            4'd1:  w_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
            4'd2:  w_word = {7'b0000001, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
            4'd3:  w_word = {7'b0000000, in_rs2, in_rs1, 3'b100, in_rd, OP_R};
            4'd4: begin
                w_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_IALU};
                w_legal = w_i_ok;
            end
            4'd5: begin
                w_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_IALU};
                w_legal = w_i_ok;
            end
            4'd6: begin
                w_word  = {7'b0000000, in_imm[4:0], in_rs1, 3'b001, in_rd, OP_IALU};
                w_legal = (in_imm[31:5] == '0);
            end
            4'd7: begin
                w_word  = {7'b0000000, in_imm[4:0], in_rs1, 3'b101, in_rd, OP_IALU};
                w_legal = (in_imm[31:5] == '0);
            end
            4'd8: begin
                w_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
                w_legal = w_i_ok;
            end
            4'd9: begin
                w_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
                w_legal = w_i_ok;
            end
            4'd10, 4'd11, 4'd12: begin
                w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                           (in_kind == 4'd10) ? 3'b000 : (in_kind == 4'd11) ? 3'b101 : 3'b100,
                           in_imm[4:1], in_imm[11], OP_BR};
                w_legal = w_b_ok;
            end
            4'd13: begin
                w_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                w_legal = w_j_ok;
            end
            4'd14: begin
                w_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
                w_legal = w_i_ok;
            end
            default: begin
                w_word  = {in_imm[31:12], in_rd, OP_AUIPC};
                w_legal = (in_imm[11:0] == '0);
            end
        endcase
    end

    assign in_ready    = (r_count != FULL_CNT);
    assign mem_wen_I   = (r_count != '0);
    assign mem_wdata_I = mem_wen_I ? r_fifo[r_rd_ptr] : '0;
    assign mem_addr_I  = r_addr;
    assign err_illegal = r_err;
    assign words_written = r_words;

    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = mem_wen_I && mem_ack_I;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= BASE_ADDR;
            r_err    <= 1'b0;
            r_words  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_addr   <= r_addr + 32'd4;
                r_words  <= r_words + 16'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only visible once the count covers it.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && w_push) begin
            r_fifo[r_wr_ptr] <= w_word;
        end
    end
endmodule

// File: tb/tb_inst_enc.sv
// tb/tb_inst_enc.sv - directed self-checking bench for inst_enc
module tb_inst_enc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_kind = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        mem_wen_I;
    logic [31:0] mem_addr_I;
    logic [31:0] mem_wdata_I;
    logic        mem_ack_I = 1'b0;
    logic        err_illegal;
    logic [15:0] words_written;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];

    inst_enc #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_wen_I(mem_wen_I), .mem_addr_I(mem_addr_I), .mem_wdata_I(mem_wdata_I),
        .mem_ack_I(mem_ack_I), .err_illegal(err_illegal), .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after posedge, so the negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (rst_n && !clear && mem_wen_I && mem_ack_I) begin
            cap_addr.push_back(mem_addr_I);
            cap_data.push_back(mem_wdata_I);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        in_valid = 1'b1; in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        for (int i = 0; i < 50 && !in_ready; i++) step();
        tests_run++;
        if (in_ready !== 1'b1) begin
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
            tests_failed++;
        end
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 50 && cap_data.size() < n; i++) step();
        tests_run++;
        if (cap_data.size() != n) begin
            $display("FAIL write_count: got %0d writes required %0d", cap_data.size(), n);
            tests_failed++;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic check_writes(input string name, input logic [31:0] exp_d[$]);
        for (int i = 0; i < exp_d.size() && i < cap_data.size(); i++) begin
            tests_run++;
            if (cap_data[i] !== exp_d[i] || cap_addr[i] !== 32'(i * 4)) begin
                $display("FAIL %s[%0d]: addr=%h data=%h required addr=%h data=%h",
                         name, i, cap_addr[i], cap_data[i], 32'(i * 4), exp_d[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        tests_run++;
        if (in_ready !== 1'b1 || mem_wen_I !== 1'b0 || mem_addr_I !== 32'h0 ||
            mem_wdata_I !== 32'h0 || err_illegal !== 1'b0 || words_written !== 16'd0) begin
            $display("FAIL reset: rdy=%b wen=%b addr=%h data=%h err=%b ww=%0d required 1 0 0 0 0 0",
                     in_ready, mem_wen_I, mem_addr_I, mem_wdata_I, err_illegal, words_written);
            tests_failed++;
        end
    endtask

    task automatic test_add();
        do_clear();
        mem_ack_I = 1'b1;
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        idle();
        wait_writes(1);
        check_writes("add", '{32'h002081B3});
        tests_run++;
        if (words_written !== 16'd1) begin
            $display("FAIL add_ww: got %0d required 1", words_written);
            tests_failed++;
        end
    endtask

    task automatic test_stream();
        do_clear();
        mem_ack_I = 1'b1;
        send(4'd4,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        send(4'd9,  5'd0, 5'd1, 5'd2, 32'd8);
        send(4'd10, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        send(4'd13, 5'd1, 5'd0, 5'd0, 32'd8);
        idle();
        wait_writes(4);
        check_writes("stream", '{32'hFFF00093, 32'h0020A423, 32'hFE208EE3, 32'h008000EF});
        tests_run++;
        if (words_written !== 16'd4) begin
            $display("FAIL stream_ww: got %0d required 4", words_written);
            tests_failed++;
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        mem_ack_I = 1'b0;
        for (int i = 1; i <= 4; i++) send(4'd4, 5'd1, 5'd0, 5'd0, 32'(i));
        idle();
        tests_run++;
        if (in_ready !== 1'b0 || mem_wen_I !== 1'b1 || mem_addr_I !== 32'h0 ||
            mem_wdata_I !== 32'h00100093) begin
            $display("FAIL full_state: rdy=%b wen=%b addr=%h data=%h required 0 1 0 00100093",
                     in_ready, mem_wen_I, mem_addr_I, mem_wdata_I);
            tests_failed++;
        end
        in_valid = 1'b1; in_imm = 32'd5;
        step(); step(); step();
        in_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b0 || mem_addr_I !== 32'h0 || mem_wdata_I !== 32'h00100093 ||
            words_written !== 16'd0) begin
            $display("FAIL frozen: rdy=%b addr=%h data=%h ww=%0d required 0 0 00100093 0",
                     in_ready, mem_addr_I, mem_wdata_I, words_written);
            tests_failed++;
        end
        mem_ack_I = 1'b1;
        wait_writes(4);
        tests_run++;
        if (in_ready !== 1'b1 || mem_wen_I !== 1'b0) begin
            $display("FAIL drained: rdy=%b wen=%b required 1 0", in_ready, mem_wen_I);
            tests_failed++;
        end
        send(4'd4, 5'd1, 5'd0, 5'd0, 32'd5);
        idle();
        wait_writes(5);
        check_writes("b2b", '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093, 32'h00500093});
    endtask

    task automatic test_illegal();
        do_clear();
        mem_ack_I = 1'b1;
        send(4'd4,  5'd1, 5'd0, 5'd0, 32'd2048);
        send(4'd10, 5'd0, 5'd1, 5'd2, 32'd3);
        idle();
        step(); step(); step();
        tests_run++;
        if (err_illegal !== 1'b1 || cap_data.size() != 0 || words_written !== 16'd0) begin
            $display("FAIL illegal: err=%b writes=%0d ww=%0d required 1 0 0",
                     err_illegal, cap_data.size(), words_written);
            tests_failed++;
        end
        send(4'd4, 5'd1, 5'd0, 5'd0, 32'd7);
        idle();
        wait_writes(1);
        check_writes("after_illegal", '{32'h00700093});
        tests_run++;
        if (err_illegal !== 1'b1) begin
            $display("FAIL err_sticky: got %b required 1", err_illegal);
            tests_failed++;
        end
    endtask

    task automatic test_clear();
        do_clear();
        mem_ack_I = 1'b1;
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        idle();
        wait_writes(1);
        mem_ack_I = 1'b0;
        send(4'd5, 5'd1, 5'd0, 5'd0, 32'hFFFF_F7FF);
        for (int i = 1; i <= 3; i++) send(4'd4, 5'd1, 5'd0, 5'd0, 32'(i));
        idle();
        tests_run++;
        if (mem_wen_I !== 1'b1 || err_illegal !== 1'b1 || words_written !== 16'd1 ||
            mem_addr_I !== 32'h4) begin
            $display("FAIL pre_clear: wen=%b err=%b ww=%0d addr=%h required 1 1 1 4",
                     mem_wen_I, err_illegal, words_written, mem_addr_I);
            tests_failed++;
        end
        do_clear();
        tests_run++;
        if (mem_wen_I !== 1'b0 || mem_addr_I !== 32'h0 || err_illegal !== 1'b0 ||
            words_written !== 16'd0 || in_ready !== 1'b1 || mem_wdata_I !== 32'h0) begin
            $display("FAIL clear: wen=%b addr=%h err=%b ww=%0d rdy=%b data=%h required 0 0 0 0 1 0",
                     mem_wen_I, mem_addr_I, err_illegal, words_written, in_ready, mem_wdata_I);
            tests_failed++;
        end
        send(4'd4, 5'd1, 5'd0, 5'd0, 32'd2);
        send(4'd6, 5'd1, 5'd0, 5'd0, 32'd32);
        send(4'd4, 5'd1, 5'd0, 5'd0, 32'd3);
        idle();
        rst_n = 1'b0;
        step();
        tests_run++;
        if (mem_wen_I !== 1'b0 || mem_addr_I !== 32'h0 || err_illegal !== 1'b0 ||
            words_written !== 16'd0 || in_ready !== 1'b1 || mem_wdata_I !== 32'h0) begin
            $display("FAIL mid_reset: wen=%b addr=%h err=%b ww=%0d rdy=%b data=%h required 0 0 0 0 1 0",
                     mem_wen_I, mem_addr_I, err_illegal, words_written, in_ready, mem_wdata_I);
            tests_failed++;
        end
        rst_n = 1'b1;
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic test_sub_mul();
        do_clear();
        mem_ack_I = 1'b1;
        send(4'd1, 5'd5, 5'd6, 5'd7, 32'd0);
        send(4'd2, 5'd5, 5'd6, 5'd7, 32'd0);
        idle();
        wait_writes(2);
        check_writes("sub_mul", '{32'h407302B3, 32'h027302B3});
    endtask

    initial begin
        test_reset();
        test_add();
        test_stream();
        test_back_to_back();
        test_illegal();
        test_clear();
        test_sub_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
